// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer.
// Owns the fetch PC and keeps at most one instruction-memory request in flight.
// Each fetched word is offered to decode through a valid/ready handshake.
// Control-flow redirects take effect as soon as the memory protocol allows.
// A fetch already issued to memory is never withdrawn; its response is
// discarded instead.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   redirect        one-cycle control-flow change pulse
//   redirect_addr   new fetch target (low two bits ignored)
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address, stable while imem_req is high
//   imem_ack        one-cycle response strobe; imem_rdata valid with it
//   imem_rdata      instruction word from memory
//   instr_valid     live instruction on instr_data/instr_pc (masked by redirect)
//   instr_ready     decode accepts the instruction
//   instr_data      fetched instruction word
//   instr_pc        address instr_data was fetched from
module fetch_seq #(
  parameter int unsigned    N          = 32,
  parameter logic [N-1:0]   RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic [N-1:0] redirect_addr,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr_data,
  output logic [N-1:0] instr_pc
);

  localparam logic [N-1:0] NOP_INSTR = N'(32'h0000_0013);
  localparam logic [N-1:0] PC_STEP   = N'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic         kill_q, kill_d;
  logic [N-1:0] idata_q, idata_d;
  logic [N-1:0] ipc_q, ipc_d;
  logic         req_q, req_d;
  logic         hold_q, hold_d;

  logic [N-1:0] redir_tgt_c;
  logic         unused_c;

  // Redirect targets are word aligned; the low address bits are dropped.
  assign redir_tgt_c = {redirect_addr[N-1:2], 2'b00};
  assign unused_c    = ^redirect_addr[1:0];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    kill_d  = kill_q;
    idata_d = idata_q;
    ipc_d   = ipc_q;

    case (state_q)
      S_IDLE: begin
        // Memory responses are meaningless here; only a redirect is honoured.
        if (redirect) begin
          pc_d = redir_tgt_c;
        end
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (kill_q || redirect) begin
            // Stale response: drop it and reissue at the newest target.
            pc_d   = redirect ? redir_tgt_c : tgt_q;
            kill_d = 1'b0;
          end else begin
            idata_d = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_STEP;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn: remember the target and poison it.
          kill_d = 1'b1;
          tgt_d  = redir_tgt_c;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt_c;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flags are registered copies of the next state decode.
    req_d  = (state_d == S_FETCH);
    hold_d = (state_d == S_HOLD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_ADDR;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
      idata_q <= NOP_INSTR;
      ipc_q   <= RESET_ADDR;
      req_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      idata_q <= idata_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  // A same-cycle redirect squashes the held (younger) instruction.
  assign instr_valid = hold_q & ~redirect;
  assign instr_data  = idata_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus a randomized run. A
// transaction-level fetch model predicts every output on every cycle.
module tb_fetch_seq;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int P_START = 0;  // waiting one cycle before the first fetch
  localparam int P_REQ   = 1;  // a fetch is out at memory
  localparam int P_OFFER = 2;  // an instruction is offered to decode

  logic        clk = 1'b0;
  logic        rst, redirect, imem_ack, instr_ready;
  logic [31:0] redirect_addr, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr_data, instr_pc;

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_data, w_pc;

  always #5 clk = ~clk;

  fetch_seq #(.N(32), .RESET_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  // Second copy starting at the top of the address space, zero-wait memory.
  assign w_ack   = w_req;
  assign w_rdata = w_addr ^ KEY;
  fetch_seq #(.N(32), .RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_addr(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .instr_valid(w_valid), .instr_ready(1'b1),
    .instr_data(w_data), .instr_pc(w_pc)
  );

  int checks = 0;
  int failures = 0;

  // Model of the fetch unit
  int          m_phase;
  logic [31:0] m_next_fetch, m_pending_tgt, m_odata, m_opc;
  bit          m_stale, m_known;

  // Stimulus controls
  bit          d_rst, d_redir, d_ready, d_force_ack;
  logic [31:0] d_raddr;
  int          mem_delay, wcnt;

  // Values sampled in the latest step
  logic        s_req, s_valid, s_ack;
  logic [31:0] s_addr, s_data, s_pc;

  logic [31:0] acc_q[$];
  logic [31:0] w_fetch[2];
  logic [31:0] w_offer[2];
  int          w_nf = 0, w_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_phase       = P_START;
    m_next_fetch  = 32'h0;
    m_pending_tgt = 32'h0;
    m_odata       = NOP;
    m_opc         = 32'h0;
    m_stale       = 1'b0;
  endtask

  // One clock: drive inputs at negedge, compare, then advance the model.
  task automatic step();
    bit          ack;
    logic [31:0] rdata;
    @(negedge clk);
    ack = 1'b0;
    if (d_rst) begin
      wcnt = 0;
    end else if (d_force_ack) begin
      ack = 1'b1;
    end else if (imem_req === 1'b1) begin
      if (wcnt >= mem_delay) begin
        ack  = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    rdata         = imem_addr ^ KEY;
    rst           = d_rst;
    redirect      = d_redir;
    redirect_addr = d_raddr;
    instr_ready   = d_ready;
    imem_ack      = ack;
    imem_rdata    = rdata;
    #1;
    s_req = imem_req; s_valid = instr_valid; s_addr = imem_addr;
    s_data = instr_data; s_pc = instr_pc; s_ack = ack;
    if (m_known) begin
      check("imem_req",    32'(s_req),   32'(m_phase == P_REQ));
      check("imem_addr",   s_addr,       m_next_fetch);
      check("instr_valid", 32'(s_valid), 32'((m_phase == P_OFFER) && !d_redir));
      check("instr_data",  s_data,       m_odata);
      check("instr_pc",    s_pc,         m_opc);
      if (s_valid === 1'b1 && d_ready) begin
        // Memory content is addr^KEY, so every delivered word must match its pc.
        check("accept_word", s_data, s_pc ^ KEY);
        acc_q.push_back(s_pc);
      end
    end
    if (w_req === 1'b1 && w_nf < 2) begin w_fetch[w_nf] = w_addr; w_nf++; end
    if (w_valid === 1'b1 && w_no < 2) begin
      check("wrap_word", w_data, w_pc ^ KEY);
      w_offer[w_no] = w_pc; w_no++;
    end
    @(posedge clk);
    if (d_rst) begin
      model_reset();
      m_known = 1'b1;
    end else begin
      case (m_phase)
        P_START: begin
          if (d_redir) m_next_fetch = word_of(d_raddr);
          m_phase = P_REQ;
        end
        P_REQ: begin
          if (ack && (m_stale || d_redir)) begin
            m_next_fetch = d_redir ? word_of(d_raddr) : m_pending_tgt;
            m_stale      = 1'b0;
          end else if (ack) begin
            m_odata      = rdata;
            m_opc        = m_next_fetch;
            m_next_fetch = m_next_fetch + 32'd4;
            m_phase      = P_OFFER;
          end else if (d_redir) begin
            m_stale       = 1'b1;
            m_pending_tgt = word_of(d_raddr);
          end
        end
        default: begin
          if (d_redir) begin
            m_next_fetch = word_of(d_raddr);
            m_phase      = P_REQ;
          end else if (d_ready) begin
            m_phase = P_REQ;
          end
        end
      endcase
    end
  endtask

  task automatic wait_valid(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_valid === 1'b1) begin got = 1'b1; break; end
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_d, held_p, old_addr;
    int          cyc;
    bit          got;

    rst = 1'b1; redirect = 1'b0; redirect_addr = '0; imem_ack = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    d_rst = 1'b1; d_redir = 1'b0; d_raddr = '0; d_ready = 1'b1; d_force_ack = 1'b0;
    mem_delay = 0; wcnt = 0; m_known = 1'b0;
    model_reset();

    // Reset values
    step(); step();
    check("rst_req",   32'(s_req),   32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data",  s_data,       NOP);
    check("rst_pc",    s_pc,         32'h0);
    check("rst_addr",  s_addr,       32'h0);

    // Zero-wait streaming from reset
    d_rst = 1'b0;
    acc_q.delete();
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) check("idle_req", 32'(s_req), 32'd0);
      if (s_valid === 1'b1) begin cyc = i; break; end
    end
    check("first_valid_cycle", 32'(cyc), 32'd3);
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) step();
    check("acc_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 3) begin
      check("acc_pc0", acc_q[0], 32'h0);
      check("acc_pc1", acc_q[1], 32'h4);
      check("acc_pc2", acc_q[2], 32'h8);
    end

    // PC wrap on the second instance
    check("wrap_nfetch", 32'(w_nf), 32'd2);
    check("wrap_nofr",   32'(w_no), 32'd2);
    if (w_nf == 2) begin
      check("wrap_fetch0", w_fetch[0], 32'hFFFF_FFFC);
      check("wrap_fetch1", w_fetch[1], 32'h0000_0000);
    end
    if (w_no == 2) check("wrap_pc1", w_offer[1], 32'h0000_0000);

    // Backpressure
    d_ready = 1'b0;
    wait_valid("bp_valid");
    held_d = m_odata; held_p = m_opc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 32'(s_valid), 32'd1);
      check("bp_data_hold",  s_data,       held_d);
      check("bp_pc_hold",    s_pc,         held_p);
      check("bp_no_req",     32'(s_req),   32'd0);
    end
    d_ready = 1'b1;
    step();
    step();
    check("bp_resume_req", 32'(s_req), 32'd1);

    // Redirect while a slow fetch is outstanding
    mem_delay = 3;
    wait_valid("rw_valid");
    old_addr = m_next_fetch;
    d_redir = 1'b1; d_raddr = 32'h100;
    step();
    d_redir = 1'b0;
    check("rw_addr_kept", s_addr, old_addr);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rw_addr_wait", s_addr, old_addr);
      if (s_ack) begin got = 1'b1; break; end
    end
    check("rw_ack_seen", 32'(got), 32'd1);
    step();
    check("rw_new_addr", s_addr,     32'h100);
    check("rw_new_req",  32'(s_req), 32'd1);
    wait_valid("rw_valid2");
    check("rw_pc", s_pc, 32'h100);

    // Redirect coincident with ready in S_HOLD
    mem_delay = 0;
    d_ready = 1'b0;
    wait_valid("hr_valid");
    d_ready = 1'b1; d_redir = 1'b1; d_raddr = 32'h200;
    step();
    d_redir = 1'b0;
    check("hr_squash", 32'(s_valid), 32'd0);
    step();
    check("hr_addr", s_addr,     32'h200);
    check("hr_req",  32'(s_req), 32'd1);
    wait_valid("hr_valid2");
    check("hr_pc", s_pc, 32'h200);

    // Unaligned redirect target
    d_ready = 1'b0;
    wait_valid("ua_valid");
    d_redir = 1'b1; d_raddr = 32'h203;
    step();
    d_redir = 1'b0;
    step();
    check("ua_addr", s_addr, 32'h200);
    d_ready = 1'b1;
    wait_valid("ua_valid2");
    check("ua_pc", s_pc, 32'h200);

    // Redirect coincident with a zero-wait ack: response discarded
    d_redir = 1'b1; d_raddr = 32'h300;
    step();
    d_redir = 1'b0;
    step();
    check("co_addr",  s_addr,       32'h300);
    check("co_valid", 32'(s_valid), 32'd0);
    wait_valid("co_valid2");
    check("co_pc", s_pc, 32'h300);

    // Reset while a fetch waits; a late ack must be ignored
    mem_delay = 5;
    d_ready = 1'b0;
    wait_valid("rs_valid");
    d_ready = 1'b1;
    step();
    step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0; d_force_ack = 1'b1;
    step();
    d_force_ack = 1'b0;
    check("rs_req",   32'(s_req),   32'd0);
    check("rs_valid", 32'(s_valid), 32'd0);
    check("rs_data",  s_data,       NOP);
    check("rs_pc",    s_pc,         32'h0);
    check("rs_addr",  s_addr,       32'h0);
    step();
    check("rs_fetch_req",  32'(s_req), 32'd1);
    check("rs_fetch_addr", s_addr,     32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      d_rst     = ($urandom_range(0, 299) == 0);
      d_redir   = ($urandom_range(0, 7) == 0);
      d_raddr   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
      d_ready   = ($urandom_range(0, 3) != 0);
      mem_delay = $urandom_range(0, 3);
      step();
    end
    d_rst = 1'b0; d_redir = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the program counter register and drives the instruction-memory request port of the RISC-V core. It consumes the next-address result computed by the PC address logic as a redirect, issues one fetch at a time to instruction memory, and presents each fetched instruction to decode through a valid/ready handshake. It sits between instruction memory and the decode stage and is the only writer of the architectural fetch PC.

## Interface
- N, 32, address/data width
- RESET_ADDR, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  one-cycle pulse: control flow change (branch taken, JAL, JALR)
- redirect_addr  in  N  new fetch target, valid with redirect
- imem_req  out  1  fetch request, held high until imem_ack
- imem_addr  out  N  fetch address, stable while imem_req high
- imem_ack  in  1  one-cycle response; imem_rdata valid in the same cycle
- imem_rdata  in  N  instruction word
- instr_valid  out  1  instr_data/instr_pc hold a live instruction
- instr_ready  in  1  decode accepts instruction
- instr_data  out  N  fetched instruction
- instr_pc  out  N  address instr_data was fetched from

## Operation
- Registers: pc (next fetch addr), kill flag, pending target tgt, instr_data, instr_pc, state.
- States: S_IDLE, S_FETCH, S_HOLD.
- S_IDLE: imem_req=0; next cycle -> S_FETCH. imem_ack in S_IDLE ignored.
- S_FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=0, redirect=1: kill<=1, tgt<=redirect_addr; imem_addr unchanged (request cannot be withdrawn).
  - imem_ack=1 and (kill=1 or redirect=1): discard rdata; pc<=redirect ? redirect_addr : tgt (redirect this cycle wins over older tgt); kill<=0; stay S_FETCH.
  - imem_ack=1, kill=0, redirect=0: instr_data<=imem_rdata, instr_pc<=pc, pc<=pc+4; -> S_HOLD.
- S_HOLD: imem_req=0; instr_valid = !redirect (combinational mask, squashes a younger instruction in the same cycle as the redirect).
  - redirect=1: pc<=redirect_addr; -> S_FETCH; instruction dropped regardless of instr_ready.
  - redirect=0, instr_ready=1: transfer completes; -> S_FETCH.
  - otherwise hold all outputs stable.
- Arithmetic: pc+4 modulo 2^N (0xFFFF_FFFC wraps to 0x0000_0000). redirect_addr[1:0] forced to 2'b00 on capture.
- redirect outside S_FETCH/S_HOLD (i.e. S_IDLE): pc<=redirect_addr, still -> S_FETCH.
- rst: overrides everything; an outstanding request is abandoned (memory is reset by the same rst).

## Timing
- Reset values (cycle after rst high): state=S_IDLE, imem_req=0, imem_addr=pc=RESET_ADDR, instr_valid=0, instr_data=32'h0000_0013 (NOP), instr_pc=RESET_ADDR, kill=0, tgt=0.
- First imem_req high 2 cycles after rst deasserts... precisely: rst low at edge t, S_IDLE during t, S_FETCH from t+1.
- Zero-wait memory (ack same cycle as req): instr_valid rises 1 cycle after ack; max throughput one instruction per 2 cycles.
- Redirect in S_HOLD at cycle t: imem_addr=redirect_addr at t+1.
- Redirect in S_FETCH with no ack at t: old address held until ack; target issued cycle after ack.
- Redirect coincident with ack: data discarded, target issued next cycle.
- Only one request outstanding; no instruction ever reaches decode from a killed fetch.

## Test plan
- Reset, memory acks every request same cycle with rdata=addr^0xA5A5_0000, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8; first instr_valid 3 cycles after rst drops; imem_req low in S_IDLE.
- Backpressure: instr_ready=0 for 5 cycles in S_HOLD -> instr_valid, instr_data, instr_pc constant, imem_req=0; no new fetch until ready.
- Redirect to 0x100 while S_FETCH waits (ack delayed 3 cycles) -> imem_addr stays old value until ack, rdata dropped, next imem_addr=0x100, next instr_pc=0x100.
- Redirect to 0x200 together with instr_ready in S_HOLD -> instr_valid low that cycle, next imem_addr=0x200; redirect to 0x203 -> fetch at 0x200.
- PC wrap: RESET_ADDR=0xFFFF_FFFC -> second fetch address 0x0000_0000.
- rst asserted mid-wait in S_FETCH -> next cycle all outputs at reset values; late imem_ack ignored.
